// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: shared interrupt source numbering, source limit and pulse FSM state type
package intr_ctrl_pkg;
  localparam int INTR_MAX_SRC = 16;
  localparam int INTR_VIDEO   = 0;
  localparam int INTR_BLIT    = 1;
  localparam int INTR_TIMER   = 2;
  localparam int INTR_AUDIO   = 3;
  typedef enum logic [1:0] {
    INTR_IDLE    = 2'd0,
    INTR_PULSE   = 2'd1,
    INTR_HOLDOFF = 2'd2
  } intr_state_t;
endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// prio_enc: lowest-set-bit encoder; in_i vector -> idx_o lowest set index, valid_o any bit set
module prio_enc #(
  parameter int WIDTH = 4,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);
  always_comb begin
    idx_o   = '0;
    valid_o = |in_i;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (in_i[i]) idx_o = IW'(i);
  end
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: sticky interrupt status/mask with pulse or level bus_intr_o; in: signal/force/clear/mask/level_mode, out: status, pending, src, src_valid, bus_intr
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int PULSE_LEN   = 1,
  parameter int HOLDOFF_LEN = 0,
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] intr_signal_i,
  input  logic [NUM_SRC-1:0] intr_force_i,
  input  logic [NUM_SRC-1:0] intr_clear_i,
  input  logic [NUM_SRC-1:0] intr_mask_i,
  input  logic               level_mode_i,
  output logic [NUM_SRC-1:0] intr_status_o,
  output logic [NUM_SRC-1:0] intr_pending_o,
  output logic [SW-1:0]      intr_src_o,
  output logic               intr_src_valid_o,
  output logic               bus_intr_o
);
  localparam logic [7:0] PL = 8'(PULSE_LEN - 1);
  localparam logic [7:0] HL = 8'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);
  logic [NUM_SRC-1:0] status_q, status_d, pending_q, pending_d, evt;
  logic [SW-1:0]      src_q, src_d, enc_idx;
  logic               valid_q, valid_d, enc_valid, bus_q, bus_d, retrig_q, retrig_d, rtr;
  logic [7:0]         cnt_q, cnt_d;
  intr_state_t        state_q, state_d;
  prio_enc #(.WIDTH(NUM_SRC)) u_enc (
    .in_i   (pending_d),
    .idx_o  (enc_idx),
    .valid_o(enc_valid)
  );
  always_comb begin
    status_d  = (status_q | intr_signal_i | intr_force_i) & ~intr_clear_i;
    evt       = (intr_signal_i | intr_force_i) & intr_mask_i & ~status_q & ~intr_clear_i;
    pending_d = status_d & intr_mask_i;
    valid_d   = enc_valid;
    src_d     = enc_valid ? enc_idx : src_q;
    rtr       = retrig_q | (|evt);
    state_d   = state_q;
    cnt_d     = cnt_q;
    retrig_d  = retrig_q;
    bus_d     = 1'b0;
    if (level_mode_i) begin
      state_d  = INTR_IDLE;
      cnt_d    = '0;
      retrig_d = 1'b0;
      bus_d    = valid_d;
    end else begin
      case (state_q)
        INTR_IDLE: if (|evt) begin
          state_d = INTR_PULSE;
          bus_d   = 1'b1;
          cnt_d   = PL;
        end
        INTR_PULSE: if (cnt_q != 8'd0) begin
          bus_d    = 1'b1;
          cnt_d    = cnt_q - 8'd1;
          retrig_d = rtr;
        end else if (HOLDOFF_LEN != 0) begin
          state_d  = INTR_HOLDOFF;
          cnt_d    = HL;
          retrig_d = rtr;
        end else if (rtr) begin
          bus_d    = 1'b1;
          cnt_d    = PL;
          retrig_d = 1'b0;
        end else begin
          state_d  = INTR_IDLE;
          retrig_d = 1'b0;
        end
        INTR_HOLDOFF: if (cnt_q != 8'd0) begin
          cnt_d    = cnt_q - 8'd1;
          retrig_d = rtr;
        end else if (rtr) begin
          state_d  = INTR_PULSE;
          bus_d    = 1'b1;
          cnt_d    = PL;
          retrig_d = 1'b0;
        end else begin
          state_d  = INTR_IDLE;
          retrig_d = 1'b0;
        end
        default: begin
          state_d  = INTR_IDLE;
          cnt_d    = '0;
          retrig_d = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      status_q  <= '0;
      pending_q <= '0;
      src_q     <= '0;
      valid_q   <= 1'b0;
      bus_q     <= 1'b0;
      state_q   <= INTR_IDLE;
      cnt_q     <= '0;
      retrig_q  <= 1'b0;
    end else begin
      status_q  <= status_d;
      pending_q <= pending_d;
      src_q     <= src_d;
      valid_q   <= valid_d;
      bus_q     <= bus_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retrig_q  <= retrig_d;
    end
  end
  assign intr_status_o    = status_q;
  assign intr_pending_o   = pending_q;
  assign intr_src_o       = src_q;
  assign intr_src_valid_o = valid_q;
  assign bus_intr_o       = bus_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed checks of three intr_ctrl configurations (defaults, 3/2 pulse/holdoff, 16 sources)
module tb_intr_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic rst0, rst1, rst2, lvl0;
  logic [3:0] sig0, frc0, clr0, msk0, st0, pd0;
  logic [1:0] src0;
  logic vld0, bus0;
  logic [3:0] sig1, msk1, st1, pd1;
  logic [1:0] src1;
  logic vld1, bus1;
  logic [15:0] frc2, st2, pd2;
  logic [3:0] src2;
  logic vld2, bus2;
  intr_ctrl u0 (
    .clk(clk), .reset_i(rst0), .intr_signal_i(sig0), .intr_force_i(frc0),
    .intr_clear_i(clr0), .intr_mask_i(msk0), .level_mode_i(lvl0),
    .intr_status_o(st0), .intr_pending_o(pd0), .intr_src_o(src0),
    .intr_src_valid_o(vld0), .bus_intr_o(bus0)
  );
  intr_ctrl #(.NUM_SRC(4), .PULSE_LEN(3), .HOLDOFF_LEN(2)) u1 (
    .clk(clk), .reset_i(rst1), .intr_signal_i(sig1), .intr_force_i(4'h0),
    .intr_clear_i(4'h0), .intr_mask_i(msk1), .level_mode_i(1'b0),
    .intr_status_o(st1), .intr_pending_o(pd1), .intr_src_o(src1),
    .intr_src_valid_o(vld1), .bus_intr_o(bus1)
  );
  intr_ctrl #(.NUM_SRC(16)) u2 (
    .clk(clk), .reset_i(rst2), .intr_signal_i(16'h0), .intr_force_i(frc2),
    .intr_clear_i(16'h0), .intr_mask_i(16'hffff), .level_mode_i(1'b0),
    .intr_status_o(st2), .intr_pending_o(pd2), .intr_src_o(src2),
    .intr_src_valid_o(vld2), .bus_intr_o(bus2)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic exp_b [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rst0 = 1; rst1 = 1; rst2 = 1; lvl0 = 0;
    sig0 = 0; frc0 = 0; clr0 = 0; msk0 = 0; sig1 = 0; msk1 = 4'hf; frc2 = 0;
    step(); step();
    rst0 = 0; rst1 = 0; rst2 = 0;
    chk("rst_status", 32'(st0), 0);
    chk("rst_pending", 32'(pd0), 0);
    chk("rst_src", 32'(src0), 0);
    chk("rst_valid", 32'(vld0), 0);
    chk("rst_bus", 32'(bus0), 0);
    msk0 = 4'hf; sig0 = 4'b0010; step(); sig0 = 0;
    chk("ev1_status", 32'(st0), 4'b0010);
    chk("ev1_pending", 32'(pd0), 4'b0010);
    chk("ev1_src", 32'(src0), 1);
    chk("ev1_valid", 32'(vld0), 1);
    chk("ev1_bus", 32'(bus0), 1);
    step();
    chk("ev1_bus_end", 32'(bus0), 0);
    sig0 = 4'b0010; step(); sig0 = 0;
    chk("rep_nobus", 32'(bus0), 0);
    chk("rep_status", 32'(st0), 4'b0010);
    clr0 = 4'b0010; step(); clr0 = 0;
    chk("clr_status", 32'(st0), 0);
    chk("clr_valid", 32'(vld0), 0);
    chk("clr_src_hold", 32'(src0), 1);
    sig0 = 4'b0010; step(); sig0 = 0;
    chk("ev2_bus", 32'(bus0), 1);
    clr0 = 4'b0010; step(); clr0 = 0;
    sig0 = 4'b0100; clr0 = 4'b0100; step(); sig0 = 0; clr0 = 0;
    chk("sigclr_status", 32'(st0), 0);
    chk("sigclr_bus", 32'(bus0), 0);
    sig0 = 4'b1001; step(); sig0 = 0;
    chk("multi_pending", 32'(pd0), 4'b1001);
    chk("multi_src", 32'(src0), 0);
    chk("multi_bus", 32'(bus0), 1);
    clr0 = 4'hf; step(); clr0 = 0;
    sig0 = 4'b0001; step();
    chk("b2b_bus1", 32'(bus0), 1);
    sig0 = 4'b0010; frc0 = 4'b0000; step(); sig0 = 0;
    chk("b2b_bus2", 32'(bus0), 1);
    step();
    chk("b2b_end", 32'(bus0), 0);
    clr0 = 4'hf; step(); clr0 = 0;
    frc0 = 4'b1000; step(); frc0 = 0;
    chk("force_status", 32'(st0), 4'b1000);
    chk("force_bus", 32'(bus0), 1);
    clr0 = 4'hf; step(); clr0 = 0;
    lvl0 = 1; msk0 = 4'b0001; sig0 = 4'b0011; step(); sig0 = 0;
    chk("lvl_bus", 32'(bus0), 1);
    chk("lvl_pending", 32'(pd0), 4'b0001);
    step();
    chk("lvl_bus_hold", 32'(bus0), 1);
    clr0 = 4'b0001; step(); clr0 = 0;
    chk("lvl_clr_bus", 32'(bus0), 0);
    chk("lvl_clr_status", 32'(st0), 4'b0010);
    msk0 = 4'b0011; step();
    chk("lvl_unmask_bus", 32'(bus0), 1);
    msk0 = 4'b0000; step();
    chk("lvl_mask_status", 32'(st0), 4'b0010);
    chk("lvl_mask_bus", 32'(bus0), 0);
    lvl0 = 0; msk0 = 4'b0011; step();
    chk("unmask_nopulse", 32'(bus0), 0);
    sig1 = 4'b0001; step(); sig1 = 0;
    chk("hp_t1", 32'(bus1), 1);
    step();
    chk("hp_t2", 32'(bus1), 1);
    sig1 = 4'b0010; step(); sig1 = 0;
    chk("hp_t3", 32'(bus1), 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("hp_t%0d", i + 4), 32'(bus1), 32'(exp_b[i]));
    end
    frc2 = 16'h8000; step(); frc2 = 0;
    chk("w16_bus", 32'(bus2), 1);
    chk("w16_src_pre", 32'(src2), 15);
    rst2 = 1; step(); rst2 = 0;
    chk("w16_rst_status", 32'(st2), 0);
    chk("w16_rst_pending", 32'(pd2), 0);
    chk("w16_rst_src", 32'(src2), 0);
    chk("w16_rst_valid", 32'(vld2), 0);
    chk("w16_rst_bus", 32'(bus2), 0);
    frc2 = 16'h8000; step(); frc2 = 0;
    chk("w16_src", 32'(src2), 15);
    chk("w16_valid", 32'(vld2), 1);
    chk("w16_bus2", 32'(bus2), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
